multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with parameterized memory wait states.
// Define MC_TRAP_EN to trap on illegal opcodes; otherwise they execute as a NOP.
module multicycle_control #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        IMM_EXEC  = 4'd10,
        IMM_WB    = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001001;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     cur, nxt;
    logic [3:0] wait_cnt;
    logic [5:0] op_q;
    logic       wait_done;
    logic       is_mem;

    assign wait_done = (wait_cnt == WAIT_LAST);
    assign is_mem    = (cur == FETCH) || (cur == MEM_READ) || (cur == MEM_WRITE);
    assign state     = cur;

    // Counter restarts on every state change so each memory state gets a full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= IDLE;
            wait_cnt <= 4'd0;
            op_q     <= 6'd0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= 4'd0;
            else if (is_mem)
                wait_cnt <= wait_cnt + 4'd1;
            if (cur == DECODE || cur == MEM_ADDR)
                op_q <= opcode;
        end
    end

    always_comb begin
        nxt           = cur;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (wait_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:      nxt = MEM_ADDR;
                    OP_R:              nxt = EXECUTE;
                    OP_BEQ:            nxt = BRANCH;
                    OP_ADDI, OP_SUBI:  nxt = IMM_EXEC;
`ifdef MC_TRAP_EN
                    default:           nxt = TRAP;
`else
                    default:           nxt = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (wait_done) nxt = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (wait_done) nxt = FETCH;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                nxt           = FETCH;
            end
            IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == OP_SUBI) ? 2'b01 : 2'b00;
                nxt       = IMM_WB;
            end
            IMM_WB: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
`ifdef MC_TRAP_EN
            TRAP: begin
                illegal = 1'b1;
                nxt     = TRAP;
            end
`endif
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: two DUTs (MEM_WAIT 0 and 2) checked cycle-by-cycle against
// per-instruction expected output sequences derived from the instruction's opcode.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

`ifdef MC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       rst0, rst2;
    logic [5:0] op0, op2;
    logic       pcw0, pcwc0, iord0, mr0, mwr0, irw0, m2r0, rdst0, rw0, asa0, ill0;
    logic       pcw2, pcwc2, iord2, mr2, mwr2, irw2, m2r2, rdst2, rw2, asa2, ill2;
    logic [1:0] asb0, aop0, psrc0, asb2, aop2, psrc2;
    logic [3:0] st0, st2;

    multicycle_control #(.MEM_WAIT(0)) u_mc0 (
        .clk(clk), .reset(rst0), .opcode(op0),
        .pc_write(pcw0), .pc_write_cond(pcwc0), .i_or_d(iord0), .mem_read(mr0),
        .mem_write(mwr0), .ir_write(irw0), .mem_to_reg(m2r0), .reg_dst(rdst0),
        .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
        .pc_source(psrc0), .state(st0), .illegal(ill0)
    );

    multicycle_control #(.MEM_WAIT(2)) u_mc2 (
        .clk(clk), .reset(rst2), .opcode(op2),
        .pc_write(pcw2), .pc_write_cond(pcwc2), .i_or_d(iord2), .mem_read(mr2),
        .mem_write(mwr2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_dst(rdst2),
        .reg_write(rw2), .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
        .pc_source(psrc2), .state(st2), .illegal(ill2)
    );

    // {state, illegal, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    //  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [20:0] obs0, obs2;
    assign obs0 = {st0, ill0, pcw0, pcwc0, iord0, mr0, mwr0, irw0, m2r0, rdst0, rw0,
                   asa0, asb0, aop0, psrc0};
    assign obs2 = {st2, ill2, pcw2, pcwc2, iord2, mr2, mwr2, irw2, m2r2, rdst2, rw2,
                   asa2, asb2, aop2, psrc2};

    typedef logic [20:0] ent_q_t[$];

    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (state got %0d exp %0d)",
                     tag, got, exp, got[20:17], exp[20:17]);
        end
    endtask

    function automatic logic [20:0] mk(int st, int ill, int pcw, int pcwc, int iord, int mr,
                                       int mwr, int irw, int m2r, int rdst, int rw,
                                       int asa, int asb, int aop, int psrc);
        return {4'(st), 1'(ill), 1'(pcw), 1'(pcwc), 1'(iord), 1'(mr), 1'(mwr), 1'(irw),
                1'(m2r), 1'(rdst), 1'(rw), 1'(asa), 2'(asb), 2'(aop), 2'(psrc)};
    endfunction

    // Expected per-cycle outputs of one whole instruction, starting at its first FETCH cycle.
    function automatic ent_q_t build(input logic [5:0] op, input int mw);
        ent_q_t q;
        for (int i = 0; i <= mw; i++)
            q.push_back(mk(1, 0, int'(i == mw), 0, 0, 1, 0, int'(i == mw), 0, 0, 0, 0, 1, 0, 0));
        q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        case (op)
            6'h23: begin
                q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                for (int i = 0; i <= mw; i++)
                    q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
            end
            6'h2b: begin
                q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                for (int i = 0; i <= mw; i++)
                    q.push_back(mk(6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            6'h00: begin
                q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
                q.push_back(mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            end
            6'h04: q.push_back(mk(9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
            6'h08, 6'h09: begin
                q.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, (op == 6'h09) ? 1 : 0, 0));
                q.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            end
            default: if (TRAP_EN) q.push_back(mk(12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        endcase
        return q;
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] v;
        int k = int'($urandom_range(0, 6));
        case (k)
            0: v = 6'h00;
            1: v = 6'h23;
            2: v = 6'h2b;
            3: v = 6'h04;
            4: v = 6'h08;
            5: v = 6'h09;
            default: v = 6'h30 | 6'($urandom_range(0, 15));
        endcase
        return v;
    endfunction

    function automatic logic [20:0] obs(input int d);
        return (d == 0) ? obs0 : obs2;
    endfunction

    task automatic set_rst(input int d, input logic v);
        if (d == 0) rst0 = v; else rst2 = v;
    endtask

    task automatic set_op(input int d, input logic [5:0] v);
        if (d == 0) op0 = v; else op2 = v;
    endtask

    task automatic do_reset(input int d, input string tag);
        set_rst(d, 1'b1);
        #1;
        chk($sformatf("d%0d %s_async", d, tag), obs(d), 21'd0);
        @(negedge clk);
        set_rst(d, 1'b0);
        #1;
        chk($sformatf("d%0d %s_idle", d, tag), obs(d), 21'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int d);
        logic [5:0] dir [8];
        logic [5:0] op;
        logic [3:0] est;
        ent_q_t     seq;
        bit         mid_rst, aborted;
        dir = '{6'h23, 6'h23, 6'h00, 6'h09, 6'h08, 6'h04, 6'h2b, 6'h3f};
        set_op(d, 6'd0);
        set_rst(d, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        do_reset(d, "init");
        for (int n = 0; n < 48; n++) begin
            op      = (n < 8) ? dir[n] : rand_op();
            mid_rst = (n == 1) || (n >= 8 && op == 6'h23 && $urandom_range(0, 3) == 0);
            aborted = 1'b0;
            seq     = build(op, d);
            for (int i = 0; i < seq.size(); i++) begin
                chk($sformatf("d%0d n%0d op%h c%0d", d, n, op, i), obs(d), seq[i]);
                est = seq[i][20:17];
                if (mid_rst && est == 4'd4) begin
                    do_reset(d, "midread");
                    aborted = 1'b1;
                    break;
                end
                // Opcode is only honoured in DECODE/MEM_ADDR; scramble it everywhere else.
                set_op(d, (est == 4'd2 || est == 4'd3) ? op : 6'($urandom));
                @(posedge clk);
                #1;
            end
            if (!aborted && seq[seq.size()-1][20:17] == 4'd12) begin
                repeat (3) begin
                    chk($sformatf("d%0d n%0d trap_hold", d, n), obs(d),
                        mk(12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                    set_op(d, 6'($urandom));
                    @(posedge clk);
                    #1;
                end
                do_reset(d, "trap");
            end
        end
    endtask

    initial begin
        fork
            run(0);
            run(2);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
